// File: rtl/branch_predictor_tournament_param.sv
// ---------------------------------------------------------------------------
// branch_predictor_tournament_param
//
// Tournament branch predictor: a PC-indexed bimodal table (P1) and a gshare
// table (P2), arbitrated by a per-PC table of saturating chooser counters.
// The global history register (GHR) is non-speculative: it only shifts on
// resolved-branch feedback. Each request exports the GHR it used so that the
// feedback can train the exact gshare entry that produced the prediction.
//
// Handshake: i_req_valid and i_fb_valid are plain qualifiers with no ready
// side. The request path is purely combinational and does not depend on
// i_req_valid; the consumer decides whether to use the outputs. A feedback
// beat is consumed on every rising clk edge where i_fb_valid is high, and
// nothing changes when it is low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req_valid           request qualifier (consumer side only)
//   i_req_pc              PC of the branch being predicted
//   i_req_target          branch target, not used internally
//   o_req_prediction      final (chosen) prediction
//   o_req_prediction1     bimodal prediction
//   o_req_prediction2     gshare prediction
//   o_req_ghr             GHR snapshot used for this request
//   i_fb_valid            resolved-branch feedback qualifier
//   i_fb_pc               PC of the resolved branch
//   i_fb_prediction       final prediction made for that branch
//   i_fb_prediction1      P1 prediction made for that branch
//   i_fb_prediction2      P2 prediction made for that branch
//   i_fb_outcome          actual outcome
//   i_fb_ghr              GHR snapshot returned from request time
//   o_mispredict_count    saturating count of final mispredictions
// ---------------------------------------------------------------------------
package branch_predictor_tournament_param_pkg;
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } branch_outcome_e;
endpackage

module branch_predictor_tournament_param
  import branch_predictor_tournament_param_pkg::*;
#(
  parameter int ADDR_WIDTH         = 32,
  parameter int PC_INDEX_BITS      = 8,
  parameter int GHR_BITS           = 8,
  parameter int CHOOSER_INDEX_BITS = 8,
  parameter int CTR_BITS           = 2,
  parameter int CHOOSER_BITS       = 2,
  parameter int STAT_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  input  logic [ADDR_WIDTH-1:0] i_req_target,
  output branch_outcome_e       o_req_prediction,
  output branch_outcome_e       o_req_prediction1,
  output branch_outcome_e       o_req_prediction2,
  output logic [GHR_BITS-1:0]   o_req_ghr,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  branch_outcome_e       i_fb_prediction,
  input  branch_outcome_e       i_fb_prediction1,
  input  branch_outcome_e       i_fb_prediction2,
  input  branch_outcome_e       i_fb_outcome,
  input  logic [GHR_BITS-1:0]   i_fb_ghr,
  output logic [STAT_WIDTH-1:0] o_mispredict_count
);

  localparam int BIM_N = 1 << PC_INDEX_BITS;
  localparam int GSH_N = 1 << GHR_BITS;
  localparam int CHO_N = 1 << CHOOSER_INDEX_BITS;

  // Weakly not-taken / weakly-P1: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0]     CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0]     CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0]     CTR_ONE  = CTR_BITS'(1);
  localparam logic [CHOOSER_BITS-1:0] CHO_INIT = {1'b0, {(CHOOSER_BITS-1){1'b1}}};
  localparam logic [CHOOSER_BITS-1:0] CHO_MAX  = '1;
  localparam logic [CHOOSER_BITS-1:0] CHO_ONE  = CHOOSER_BITS'(1);
  localparam logic [STAT_WIDTH-1:0]   STAT_MAX = '1;
  localparam logic [STAT_WIDTH-1:0]   STAT_ONE = STAT_WIDTH'(1);

  logic [CTR_BITS-1:0]     bim_q [BIM_N];
  logic [CTR_BITS-1:0]     gsh_q [GSH_N];
  logic [CHOOSER_BITS-1:0] cho_q [CHO_N];
  logic [GHR_BITS-1:0]     ghr_q;
  logic [STAT_WIDTH-1:0]   mis_q;

  // ---------------- request path (combinational) ----------------
  logic [PC_INDEX_BITS-1:0]      req_bim_idx;
  logic [GHR_BITS-1:0]           req_gsh_idx;
  logic [CHOOSER_INDEX_BITS-1:0] req_cho_idx;

  assign req_bim_idx = i_req_pc[PC_INDEX_BITS+1:2];
  assign req_gsh_idx = i_req_pc[GHR_BITS+1:2] ^ ghr_q;
  assign req_cho_idx = i_req_pc[CHOOSER_INDEX_BITS+1:2];

  assign o_req_prediction1 = branch_outcome_e'(bim_q[req_bim_idx][CTR_BITS-1]);
  assign o_req_prediction2 = branch_outcome_e'(gsh_q[req_gsh_idx][CTR_BITS-1]);
  // Chooser MSB clear selects P1, set selects P2.
  assign o_req_prediction  = cho_q[req_cho_idx][CHOOSER_BITS-1] ? o_req_prediction2
                                                                 : o_req_prediction1;
  assign o_req_ghr          = ghr_q;
  assign o_mispredict_count = mis_q;

  // ---------------- feedback path ----------------
  logic [PC_INDEX_BITS-1:0]      fb_bim_idx;
  logic [GHR_BITS-1:0]           fb_gsh_idx;
  logic [CHOOSER_INDEX_BITS-1:0] fb_cho_idx;
  logic                          fb_taken;
  logic [CTR_BITS-1:0]           bim_cur, bim_d;
  logic [CTR_BITS-1:0]           gsh_cur, gsh_d;
  logic [CHOOSER_BITS-1:0]       cho_cur, cho_d;
  logic [GHR_BITS-1:0]           ghr_d;
  logic [STAT_WIDTH-1:0]         mis_d;

  assign fb_bim_idx = i_fb_pc[PC_INDEX_BITS+1:2];
  // Train the gshare entry the request actually read, hence the snapshot.
  assign fb_gsh_idx = i_fb_pc[GHR_BITS+1:2] ^ i_fb_ghr;
  assign fb_cho_idx = i_fb_pc[CHOOSER_INDEX_BITS+1:2];
  assign fb_taken   = (i_fb_outcome == TAKEN);

  assign bim_cur = bim_q[fb_bim_idx];
  assign gsh_cur = gsh_q[fb_gsh_idx];
  assign cho_cur = cho_q[fb_cho_idx];

  always_comb begin
    bim_d = bim_cur;
    gsh_d = gsh_cur;
    cho_d = cho_cur;
    ghr_d = {ghr_q[GHR_BITS-2:0], fb_taken};
    mis_d = mis_q;

    if (fb_taken) begin
      if (bim_cur != CTR_MAX) bim_d = bim_cur + CTR_ONE;
      if (gsh_cur != CTR_MAX) gsh_d = gsh_cur + CTR_ONE;
    end else begin
      if (bim_cur != '0) bim_d = bim_cur - CTR_ONE;
      if (gsh_cur != '0) gsh_d = gsh_cur - CTR_ONE;
    end

    // Chooser only learns when the two components disagreed; exactly one
    // of them was then right.
    if (i_fb_prediction1 != i_fb_prediction2) begin
      if (i_fb_prediction1 == i_fb_outcome) begin
        if (cho_cur != '0) cho_d = cho_cur - CHO_ONE;
      end else begin
        if (cho_cur != CHO_MAX) cho_d = cho_cur + CHO_ONE;
      end
    end

    if ((i_fb_prediction != i_fb_outcome) && (mis_q != STAT_MAX)) begin
      mis_d = mis_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BIM_N; i++) bim_q[i] <= CTR_INIT;
      for (int i = 0; i < GSH_N; i++) gsh_q[i] <= CTR_INIT;
      for (int i = 0; i < CHO_N; i++) cho_q[i] <= CHO_INIT;
      ghr_q <= '0;
      mis_q <= '0;
    end else if (i_fb_valid) begin
      bim_q[fb_bim_idx] <= bim_d;
      gsh_q[fb_gsh_idx] <= gsh_d;
      cho_q[fb_cho_idx] <= cho_d;
      ghr_q             <= ghr_d;
      mis_q             <= mis_d;
    end
  end

  // Request qualifier, target and high PC bits carry no information here.
  logic unused_ok;
  assign unused_ok = ^{i_req_valid, i_req_target, i_req_pc, i_fb_pc};

endmodule

// File: tb/tb_branch_predictor_tournament_param.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_tournament_param
//
// Directed bench for the tournament predictor with default parameters.
// Expected values are hand-derived from the table/GHR rules; the GHR
// snapshot passed back on feedback is the bench's own running value.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_branch_predictor_tournament_param;
  import branch_predictor_tournament_param_pkg::*;

  localparam branch_outcome_e T = TAKEN;
  localparam branch_outcome_e N = NOT_TAKEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic            req_valid;
  logic [31:0]     req_pc;
  logic [31:0]     req_target;
  branch_outcome_e pred, pred1, pred2;
  logic [7:0]      req_ghr;
  logic            fb_valid;
  logic [31:0]     fb_pc;
  branch_outcome_e fb_pred, fb_pred1, fb_pred2, fb_outcome;
  logic [7:0]      fb_ghr;
  logic [15:0]     mis_count;

  branch_predictor_tournament_param dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_req_valid        (req_valid),
    .i_req_pc           (req_pc),
    .i_req_target       (req_target),
    .o_req_prediction   (pred),
    .o_req_prediction1  (pred1),
    .o_req_prediction2  (pred2),
    .o_req_ghr          (req_ghr),
    .i_fb_valid         (fb_valid),
    .i_fb_pc            (fb_pc),
    .i_fb_prediction    (fb_pred),
    .i_fb_prediction1   (fb_pred1),
    .i_fb_prediction2   (fb_pred2),
    .i_fb_outcome       (fb_outcome),
    .i_fb_ghr           (fb_ghr),
    .o_mispredict_count (mis_count)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Request at pc and compare all predictor outputs.
  task automatic check_req(input string tag, input logic [31:0] pc,
                           input branch_outcome_e e1, input branch_outcome_e e2,
                           input branch_outcome_e ef, input logic [7:0] eghr,
                           input logic [15:0] ecnt);
    req_valid = 1'b1;
    req_pc    = pc;
    #1;
    check({tag, ".p1"},  32'(pred1),     32'(e1));
    check({tag, ".p2"},  32'(pred2),     32'(e2));
    check({tag, ".fin"}, 32'(pred),      32'(ef));
    check({tag, ".ghr"}, 32'(req_ghr),   32'(eghr));
    check({tag, ".cnt"}, 32'(mis_count), 32'(ecnt));
  endtask

  // ---------------- driver ----------------
  // One feedback beat. The snapshot is taken from bench_ghr, which is then
  // advanced the same way the predictor's GHR should be.
  logic [7:0] bench_ghr = 8'h00;

  task automatic feedback(input logic [31:0] pc, input branch_outcome_e p,
                          input branch_outcome_e p1, input branch_outcome_e p2,
                          input branch_outcome_e outcome);
    fb_valid   = 1'b1;
    fb_pc      = pc;
    fb_pred    = p;
    fb_pred1   = p1;
    fb_pred2   = p2;
    fb_outcome = outcome;
    fb_ghr     = bench_ghr;
    @(posedge clk);
    #1;
    fb_valid  = 1'b0;
    bench_ghr = {bench_ghr[6:0], outcome == TAKEN};
  endtask

  initial begin
    req_valid  = 1'b0;
    req_pc     = '0;
    req_target = '0;
    fb_valid   = 1'b0;
    fb_pc      = '0;
    fb_pred    = N;
    fb_pred1   = N;
    fb_pred2   = N;
    fb_outcome = N;
    fb_ghr     = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset state
    check_req("reset", 32'h100, N, N, N, 8'h00, 16'd0);

    // 2: two TAKEN on 0x100 with P1=P2=NT -> bimodal[0x40]=3, GHR=3, count=2.
    //    gshare[0x40^3] still weak NT; chooser[0x40]=1 picks P1.
    repeat (2) feedback(32'h100, N, N, N, T);
    check_req("train2", 32'h100, T, N, T, 8'h03, 16'd2);

    // 3: five more TAKEN -> bimodal saturates, GHR=0x7F, count=7.
    repeat (5) feedback(32'h100, N, N, N, T);
    check_req("sat_hi", 32'h100, T, N, T, 8'h7F, 16'd7);

    //    ten NOT_TAKEN, correctly predicted -> bimodal to 0 and held,
    //    gshare[0x40] trained down twice (snapshots 0x00), GHR back to 0.
    repeat (10) feedback(32'h100, N, N, N, N);
    check_req("sat_lo", 32'h100, N, N, N, 8'h00, 16'd7);

    // 4: pc 0x200, P1=T wrong, P2=NT right -> chooser[0x80] 1->2->3.
    feedback(32'h200, T, T, N, N);
    feedback(32'h200, T, T, N, N);
    check_req("cho_up", 32'h200, N, N, N, 8'h00, 16'd9);
    //    agreeing TAKEN feedback leaves chooser alone: bimodal[0x80]=2,
    //    gshare[0x80]=1, gshare[0x81]=2, GHR=3.
    feedback(32'h200, T, T, T, T);
    feedback(32'h200, T, T, T, T);
    //    P1=T, P2=gshare[0x83]=NT; chooser strong P2 -> final NT.
    check_req("fin_p2", 32'h200, T, N, N, 8'h03, 16'd9);
    //    chooser[0x40] untouched: P1=NT, P2=gshare[0x43]=T, final follows P1.
    check_req("cho_keep", 32'h100, N, T, N, 8'h03, 16'd9);

    // 5: same-cycle request and feedback on 0x300 -> read before write.
    req_pc     = 32'h300;
    fb_valid   = 1'b1;
    fb_pc      = 32'h300;
    fb_pred    = N;
    fb_pred1   = N;
    fb_pred2   = N;
    fb_outcome = T;
    fb_ghr     = bench_ghr;
    #1;
    check("rbw_old.p1",  32'(pred1), 32'(N));
    check("rbw_old.fin", 32'(pred),  32'(N));
    @(posedge clk);
    #1;
    fb_valid  = 1'b0;
    bench_ghr = {bench_ghr[6:0], 1'b1};
    //    bimodal[0xC0]=2 -> T; P2 reads gshare[0xC0^7] = weak NT.
    check_req("rbw_new", 32'h300, T, N, T, 8'h07, 16'd10);

    // 6: asynchronous reset between edges wipes everything at once.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_req("areset_300", 32'h300, N, N, N, 8'h00, 16'd0);
    check_req("areset_100", 32'h100, N, N, N, 8'h00, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bench_ghr = 8'h00;
    @(posedge clk);
    #1;

    //    feedback with fb_valid low must not change anything.
    fb_pc      = 32'h100;
    fb_outcome = T;
    fb_pred    = N;
    repeat (3) @(posedge clk);
    #1;
    check_req("fb_idle", 32'h100, N, N, N, 8'h00, 16'd0);

    //    fresh training after reset: one TAKEN, GHR=1, count=1.
    feedback(32'h100, N, N, N, T);
    check_req("post_rst", 32'h100, T, N, T, 8'h01, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predictor_tournament_param.md
Name: branch_predictor_tournament_param

Overview:
Parametrised tournament branch predictor: a PC-indexed bimodal predictor (P1) and a gshare predictor (P2) arbitrated by a per-PC chooser table of saturating counters. It replaces the single global chooser counter with per-index choosers and carries a GHR snapshot through the pipeline for correct gshare training. It sits in the IF stage (request) and takes resolved-branch feedback from EX.

Parameters:
PC_INDEX_BITS, 8, log2 entries of bimodal PHT; index = pc[PC_INDEX_BITS+1:2]
GHR_BITS, 8, global history length and log2 entries of gshare PHT
CHOOSER_INDEX_BITS, 8, log2 entries of chooser table; index = pc[CHOOSER_INDEX_BITS+1:2]
CTR_BITS, 2, width of P1/P2 saturating counters (>=2)
CHOOSER_BITS, 2, width of chooser counters (>=2)
STAT_WIDTH, 16, width of mispredict statistics counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  prediction request valid
i_req_pc  in  ADDR_WIDTH  branch PC
i_req_target  in  ADDR_WIDTH  branch target (unused internally, kept for interface uniformity)
o_req_prediction  out  BranchOutcome  final prediction
o_req_prediction1  out  BranchOutcome  bimodal prediction
o_req_prediction2  out  BranchOutcome  gshare prediction
o_req_ghr  out  GHR_BITS  GHR snapshot used for this request; piped to feedback
i_fb_valid  in  1  feedback valid
i_fb_pc  in  ADDR_WIDTH  resolved branch PC
i_fb_prediction  in  BranchOutcome  final prediction made for this branch
i_fb_prediction1  in  BranchOutcome  P1 prediction made for this branch
i_fb_prediction2  in  BranchOutcome  P2 prediction made for this branch
i_fb_outcome  in  BranchOutcome  actual outcome
i_fb_ghr  in  GHR_BITS  GHR snapshot returned from request time
o_mispredict_count  out  STAT_WIDTH  saturating count of final mispredictions

Behaviour:
- Reset (async, rst_n=0): all P1/P2 counters = 2^(CTR_BITS-1)-1 (weakly not taken); all choosers = 2^(CHOOSER_BITS-1)-1 (weakly P1); GHR = 0; o_mispredict_count = 0. Reset mid-operation discards all state immediately; outputs reflect reset tables combinationally.
- Request path is combinational, zero latency, independent of i_req_valid (valid is a qualifier for the consumer only).
- P1 = TAKEN iff MSB of bimodal[pc idx]; P2 = TAKEN iff MSB of gshare[pc[GHR_BITS+1:2] ^ GHR]; o_req_ghr = current GHR.
- Final: chooser MSB=0 -> P1, MSB=1 -> P2.
- Feedback (posedge clk, i_fb_valid=1), all updates in the same cycle:
  - bimodal[fb idx]: TAKEN -> +1 saturating at 2^CTR_BITS-1; NOT_TAKEN -> -1 saturating at 0.
  - gshare[i_fb_pc[GHR_BITS+1:2] ^ i_fb_ghr]: same rule (uses the snapshot, not the live GHR).
  - chooser[fb idx]: unchanged if i_fb_prediction1 == i_fb_prediction2; else if P1 correct -> -1 saturating at 0; else (P2 correct) -> +1 saturating at 2^CHOOSER_BITS-1.
  - GHR <= {GHR[GHR_BITS-2:0], outcome==TAKEN}.
  - i_fb_prediction != i_fb_outcome -> o_mispredict_count +1, saturating at all-ones.
- i_fb_valid=0: no state changes.
- Same-cycle request and feedback to the same entry: request sees pre-update values (read-before-write); the update is visible from the next cycle.
- GHR is non-speculative (feedback only); no flush/repair input is needed.

Test Plan:
- Reset then request pc=0x100 -> prediction1/2/final = NOT_TAKEN, o_req_ghr=0, count=0.
- 2 TAKEN feedbacks on pc=0x100 with P1=P2=NOT_TAKEN -> bimodal[0x40] reaches 3; final = TAKEN; chooser unchanged at 1; GHR=0x03; count=2.
- 5 more TAKEN on same pc -> bimodal holds at 3 (saturation), GHR=0x7F, count=7; 10 NOT_TAKEN -> counter holds at 0 and the next request predicts NOT_TAKEN.
- Feedback with pred1=TAKEN, pred2=NOT_TAKEN, outcome=NOT_TAKEN, repeated twice on pc=0x200 -> chooser[0x80] goes 1->2->3; final follows P2; chooser[0x40] unchanged.
- Same cycle: request and feedback both on pc=0x300, outcome TAKEN -> request returns old value (NOT_TAKEN); the next-cycle request returns the updated value.
- Assert rst_n low asynchronously between clock edges after training -> all outputs return to reset values immediately and GHR=0.
